// File: rtl/wave_play_dac_pkg.sv
// Shared audio definitions for the codec playback and capture paths.
// Frame geometry, synchroniser depth and fetch FSM encoding.
package wave_play_dac_pkg;

    localparam int FRAME_BITS  = 64;
    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/audio_edge_sync.sv
// Brings an asynchronous codec clock into the system domain and
// emits single-cycle rise/fall pulses from the synchronised level.
module audio_edge_sync
    import wave_play_dac_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/wave_play_dac.sv
// Playback path: fetches one stereo word per frame from the DDR read side
// and shifts it MSB-first onto the codec DACDAT pin.
module wave_play_dac #(
    parameter int FRAME_BITS = wave_play_dac_pkg::FRAME_BITS,
    parameter int RD_TIMEOUT = 1023,
    parameter int UNDERRUN_W = 16
) (
    input  logic                  clock_50M,
    input  logic                  reset,
    input  logic                  play_en,
    input  logic                  dacclk,
    input  logic                  bclk,
    input  logic [FRAME_BITS-1:0] wav_rd_data,
    input  logic                  wav_rd_valid,
    output logic                  wav_rden,
    output logic                  dacdat,
    output logic                  underrun,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    import wave_play_dac_pkg::*;

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

    logic w_fs_start;
    logic w_bclk_fall;
    logic w_unused_lrck_lvl;
    logic w_unused_lrck_fall;
    logic w_unused_bclk_lvl;
    logic w_unused_bclk_rise;
    logic w_consume;
    logic w_store;

    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_dacdat;
    logic                  r_underrun;
    logic [UNDERRUN_W-1:0] r_ucnt;
    logic [FRAME_BITS-1:0] r_hold;
    logic                  r_hold_full;
    logic [1:0]            r_state;
    logic [TMO_W-1:0]      r_tmo;

    audio_edge_sync u_lrck_sync (
        .i_clk   (clock_50M),
        .i_rst   (reset),
        .i_async (dacclk),
        .o_level (w_unused_lrck_lvl),
        .o_rise  (w_fs_start),
        .o_fall  (w_unused_lrck_fall)
    );

    audio_edge_sync u_bclk_sync (
        .i_clk   (clock_50M),
        .i_rst   (reset),
        .i_async (bclk),
        .o_level (w_unused_bclk_lvl),
        .o_rise  (w_unused_bclk_rise),
        .o_fall  (w_bclk_fall)
    );

    assign w_consume = w_fs_start & play_en & r_hold_full;
    assign w_store   = (r_state == ST_WAIT) & wav_rd_valid;

    // Frame start beats a coincident bclk fall; the bit event is dropped.
    always_ff @(posedge clock_50M or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= CNT_W'(FRAME_BITS);
            r_dacdat   <= 1'b0;
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            r_underrun <= 1'b0;
            if (w_fs_start) begin
                r_bit_cnt <= CNT_W'(1);
                if (w_consume) begin
                    r_shift  <= r_hold;
                    r_dacdat <= r_hold[FRAME_BITS-1];
                end else begin
                    r_shift  <= '0;
                    r_dacdat <= 1'b0;
                end
                if (play_en && !r_hold_full) begin
                    r_underrun <= 1'b1;
                    if (r_ucnt != '1)
                        r_ucnt <= r_ucnt + UNDERRUN_W'(1);
                end
            end else if (w_bclk_fall) begin
                if (r_bit_cnt < CNT_W'(FRAME_BITS)) begin
                    r_shift   <= r_shift << 1;
                    r_dacdat  <= r_shift[FRAME_BITS-2];
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end else begin
                    r_dacdat  <= 1'b0;
                end
            end
        end
    end

    // A word landing with a frame start is kept for the following frame.
    always_ff @(posedge clock_50M or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_state     <= ST_IDLE;
            r_tmo       <= '0;
        end else begin
            if (w_store) begin
                r_hold      <= wav_rd_data;
                r_hold_full <= 1'b1;
            end else if (w_consume) begin
                r_hold_full <= 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (!r_hold_full && play_en)
                        r_state <= ST_REQ;
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                    r_tmo   <= '0;
                end
                ST_WAIT: begin
                    if (wav_rd_valid)
                        r_state <= ST_IDLE;
                    else if (r_tmo == TMO_W'(RD_TIMEOUT - 1))
                        r_state <= ST_IDLE;
                    else
                        r_tmo <= r_tmo + TMO_W'(1);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wav_rden     = (r_state == ST_REQ);
    assign dacdat       = r_dacdat;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ucnt;

endmodule

// File: tb/tb_wave_play_dac.sv
// Directed bench for wave_play_dac: playback, underrun, late data,
// short frame, mute and asynchronous reset scenarios.
module tb_wave_play_dac;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_en;
    logic        dacclk;
    logic        bclk;
    logic [63:0] wav_rd_data;
    logic        wav_rd_valid;
    logic        wav_rden;
    logic        dacdat;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int rden_cnt = 0;
    int rden_last = 0;
    int rden_per = 0;
    int rsp_dly = 0;
    bit rsp_en = 0;
    logic [63:0] rsp_word = '0;
    bit man_valid = 0;
    logic [63:0] man_word = '0;

    localparam logic [63:0] W1 = 64'hA5A5_0001_5A5A_8000;
    localparam logic [63:0] W2 = 64'h1234_5678_9ABC_DEF1;
    localparam logic [63:0] W3 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] W4 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] WL = 64'hC3C3_0F0F_AAAA_5555;
    localparam logic [63:0] W6 = 64'hF0F0_1234_0000_0003;

    wave_play_dac dut (
        .clock_50M    (clk),
        .reset        (reset),
        .play_en      (play_en),
        .dacclk       (dacclk),
        .bclk         (bclk),
        .wav_rd_data  (wav_rd_data),
        .wav_rd_valid (wav_rd_valid),
        .wav_rden     (wav_rden),
        .dacdat       (dacdat),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Advance to the next falling edge and act as the DDR read side.
    task automatic tick();
        @(negedge clk);
        cyc++;
        wav_rd_valid = 1'b0;
        if (man_valid) begin
            wav_rd_valid = 1'b1;
            wav_rd_data  = man_word;
            man_valid    = 0;
        end
        if (rsp_dly > 0) begin
            rsp_dly--;
            if (rsp_dly == 0) begin
                wav_rd_valid = 1'b1;
                wav_rd_data  = rsp_word;
            end
        end
        if (wav_rden === 1'b1) begin
            rden_cnt++;
            rden_per  = cyc - rden_last;
            rden_last = cyc;
            if (rsp_en)
                rsp_dly = 3;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic wait_rden(input string nm);
        int c0;
        c0 = rden_cnt;
        for (int i = 0; i < 2000 && rden_cnt == c0; i++)
            tick();
        checks++;
        if (rden_cnt == c0) begin
            errs++;
            $display("FAIL %s: no wav_rden within 2000 cycles", nm);
        end
    endtask

    // One fs frame: dacclk rise, then nfall bclk periods of 16 cycles.
    task automatic run_frame(input int nfall, input logic [63:0] w,
                             input bit chk, input bit exp_ur,
                             input int exp_cnt, input bit late,
                             input logic [63:0] lw, input string nm);
        logic [63:0] t;
        logic        eb;
        dacclk = 1'b1;
        tick();
        if (late) begin
            man_valid = 1;
            man_word  = lw;
        end
        tick();
        tick();
        eb = chk & w[63];
        checks++;
        if (dacdat !== eb) begin
            errs++;
            $display("FAIL %s bit0: dacdat=%b want %b", nm, dacdat, eb);
        end
        checks++;
        if (underrun !== exp_ur) begin
            errs++;
            $display("FAIL %s underrun: got %b want %b", nm, underrun, exp_ur);
        end
        checks++;
        if (underrun_cnt !== 16'(exp_cnt)) begin
            errs++;
            $display("FAIL %s underrun_cnt: got %0d want %0d", nm, underrun_cnt, exp_cnt);
        end
        ticks(5);
        for (int f = 1; f <= nfall; f++) begin
            bclk = 1'b0;
            ticks(3);
            t  = w << f;
            eb = chk & t[63];
            checks++;
            if (dacdat !== eb) begin
                errs++;
                $display("FAIL %s fall %0d: dacdat=%b want %b", nm, f, dacdat, eb);
            end
            ticks(5);
            bclk = 1'b1;
            dacclk = 1'b0;
            ticks(8);
        end
        dacclk = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        play_en = 1'b0;
        dacclk = 1'b0;
        bclk = 1'b1;
        wav_rd_data = '0;
        wav_rd_valid = 1'b0;
        ticks(3);
        checks++;
        if ({wav_rden, dacdat, underrun} !== 3'b000 || underrun_cnt !== 16'd0) begin
            errs++;
            $display("FAIL reset_hold: rden=%b dacdat=%b ur=%b cnt=%0d want all 0",
                     wav_rden, dacdat, underrun, underrun_cnt);
        end
        reset = 1'b0;
        ticks(3);
        checks++;
        if ({wav_rden, dacdat, underrun} !== 3'b000 || underrun_cnt !== 16'd0) begin
            errs++;
            $display("FAIL reset_release: rden=%b dacdat=%b ur=%b cnt=%0d want all 0",
                     wav_rden, dacdat, underrun, underrun_cnt);
        end
    endtask

    task automatic test_mute();
        run_frame(64, '0, 0, 0, 0, 0, '0, "mute");
        checks++;
        if (rden_cnt != 0) begin
            errs++;
            $display("FAIL mute_rden: rden pulses=%0d want 0", rden_cnt);
        end
        rsp_en = 1;
        rsp_word = W1;
        play_en = 1'b1;
        ticks(2);
        checks++;
        if (rden_cnt != 1) begin
            errs++;
            $display("FAIL unmute_fetch: rden pulses=%0d want 1", rden_cnt);
        end
        ticks(6);
    endtask

    task automatic test_normal();
        rsp_word = W2;
        run_frame(64, W1, 1, 0, 0, 0, '0, "play_w1");
        checks++;
        if (rden_cnt != 2) begin
            errs++;
            $display("FAIL play_w1_rden: rden pulses=%0d want 2", rden_cnt);
        end
        rsp_word = W3;
        run_frame(64, W2, 1, 0, 0, 0, '0, "play_w2");
        checks++;
        if (rden_cnt != 3) begin
            errs++;
            $display("FAIL play_w2_rden: rden pulses=%0d want 3", rden_cnt);
        end
    endtask

    task automatic test_short();
        rsp_word = W4;
        run_frame(40, W3, 1, 0, 0, 0, '0, "short_w3");
        rsp_en = 0;
        run_frame(64, W4, 1, 0, 0, 0, '0, "after_short_w4");
    endtask

    task automatic test_underrun();
        run_frame(64, '0, 0, 1, 1, 0, '0, "underrun1");
        run_frame(64, '0, 0, 1, 2, 0, '0, "underrun2");
        run_frame(64, '0, 0, 1, 3, 0, '0, "underrun3");
        checks++;
        if (rden_per != 1025) begin
            errs++;
            $display("FAIL rden_period: got %0d want 1025", rden_per);
        end
    endtask

    task automatic test_late();
        wait_rden("late_sync");
        ticks(2);
        run_frame(64, '0, 0, 1, 4, 1, WL, "late_frame");
        run_frame(64, WL, 1, 0, 4, 0, '0, "late_next");
    endtask

    task automatic test_async_reset();
        rsp_en = 1;
        rsp_word = W6;
        wait_rden("reset_fetch");
        ticks(5);
        dacclk = 1'b1;
        ticks(3);
        checks++;
        if (dacdat !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset_dacdat: got %b want 1", dacdat);
        end
        #5;
        reset = 1'b1;
        dacclk = 1'b0;
        rsp_en = 0;
        #1;
        checks++;
        if ({wav_rden, dacdat, underrun} !== 3'b000 || underrun_cnt !== 16'd0) begin
            errs++;
            $display("FAIL async_reset: rden=%b dacdat=%b ur=%b cnt=%0d want all 0",
                     wav_rden, dacdat, underrun, underrun_cnt);
        end
        ticks(2);
        reset = 1'b0;
        ticks(4);
        run_frame(4, '0, 0, 1, 1, 0, '0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_mute();
        test_normal();
        test_short();
        test_underrun();
        test_late();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
